// File: rtl/mac_operand_sequencer_if.sv
// Host/MAC-side bundle for mac_operand_sequencer: buffer write port, go/num_pairs
// control, and the registered operand/control outputs that feed the neuron MAC.
interface mac_operand_sequencer_if #(
  parameter int N_INPUTS = 8
);
  localparam int AW = $clog2(N_INPUTS);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_a;
  logic [7:0]    wr_w;
  logic [AW:0]   num_pairs;
  logic          go;
  logic [7:0]    An;
  logic [7:0]    Wn;
  logic [2:0]    counter;
  logic          start;
  logic          stop;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_a, wr_w, num_pairs, go,
    input  An, Wn, counter, start, stop, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_a, wr_w, num_pairs, go,
    output An, Wn, counter, start, stop, busy, done
  );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Replays buffered activation/weight pairs through the CORDIC multiply schedule.
// Optional SEQ_ZERO_SKIP_EN: pairs with a zero operand are skipped (1 scan cycle each).
module mac_operand_sequencer #(
  parameter int N_INPUTS = 8,
  parameter int ITER     = 8
) (
  input logic                    clk,
  input logic                    rst,
  mac_operand_sequencer_if.slave bus
);
  localparam int         AW       = $clog2(N_INPUTS);
  localparam int         NW       = AW + 1;
  localparam logic [2:0] CNT_LAST = 3'(ITER - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    STOP,
    DONE,
    SCAN
  } state_t;

  state_t        state_q;
  logic [AW-1:0] idx_q;
  logic [NW-1:0] np_q;
  logic [7:0]    an_q;
  logic [7:0]    wn_q;
  logic [2:0]    cnt_q;
  logic          start_q;
  logic          stop_q;
  logic          busy_q;
  logic          done_q;
  logic [15:0]   mem_q [N_INPUTS];

  logic [NW-1:0] np_d;
  logic [AW-1:0] tgt_d;
  logic [15:0]   tgt_pair_d;
  logic          tgt_skip_d;
  logic          last_d;

  // tgt_d is the pair about to be launched: 0 from IDLE, otherwise the one after idx_q.
  always_comb begin
    np_d       = (bus.num_pairs > NW'(N_INPUTS)) ? NW'(N_INPUTS) : bus.num_pairs;
    tgt_d      = (state_q == IDLE) ? '0 : idx_q + 1'b1;
    tgt_pair_d = mem_q[tgt_d];
    last_d     = ({1'b0, idx_q} == np_q - 1'b1);
`ifdef SEQ_ZERO_SKIP_EN
    tgt_skip_d = (tgt_pair_d[15:8] == 8'd0) || (tgt_pair_d[7:0] == 8'd0);
`else
    tgt_skip_d = 1'b0;
`endif
  end

  // Operand buffer is never reset; host writes are locked out while an evaluation runs.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_q && (32'(bus.wr_addr) < N_INPUTS)) begin
      mem_q[bus.wr_addr] <= {bus.wr_a, bus.wr_w};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      np_q    <= '0;
      an_q    <= '0;
      wn_q    <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.go) begin
            np_q   <= np_d;
            idx_q  <= '0;
            busy_q <= 1'b1;
            if (np_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (tgt_skip_d) begin
              state_q <= SCAN;
            end else begin
              state_q <= START;
              start_q <= 1'b1;
              cnt_q   <= '0;
              an_q    <= tgt_pair_d[15:8];
              wn_q    <= tgt_pair_d[7:0];
            end
          end
        end
        START: begin
          start_q <= 1'b0;
          if (ITER > 1) begin
            state_q <= RUN;
            cnt_q   <= cnt_q + 3'd1;
          end else begin
            state_q <= STOP;
            stop_q  <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= STOP;
            stop_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        STOP: begin
          stop_q <= 1'b0;
          if (last_d) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q <= tgt_d;
            if (tgt_skip_d) begin
              state_q <= SCAN;
            end else begin
              state_q <= START;
              start_q <= 1'b1;
              cnt_q   <= '0;
              an_q    <= tgt_pair_d[15:8];
              wn_q    <= tgt_pair_d[7:0];
            end
          end
        end
`ifdef SEQ_ZERO_SKIP_EN
        SCAN: begin
          if (last_d) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q <= tgt_d;
            if (!tgt_skip_d) begin
              state_q <= START;
              start_q <= 1'b1;
              cnt_q   <= '0;
              an_q    <= tgt_pair_d[15:8];
              wn_q    <= tgt_pair_d[7:0];
            end
          end
        end
`endif
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.An      = an_q;
  assign bus.Wn      = wn_q;
  assign bus.counter = cnt_q;
  assign bus.start   = start_q;
  assign bus.stop    = stop_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: table of pair-count cases, hand-written corner
// sequences, and randomized runs checked cycle by cycle against a trace model.
module tb_mac_operand_sequencer;
  localparam int N_INPUTS = 8;
  localparam int ITER     = 8;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] wn;
    logic [2:0] cnt;
    logic       st;
    logic       sp;
    logic       bz;
    logic       dn;
  } obs_t;

  typedef struct {
    int np;
    int exp_stops;
    int exp_done_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [7:0] mdl_a [N_INPUTS];
  logic [7:0] mdl_w [N_INPUTS];
  logic [7:0] last_an;
  logic [7:0] last_wn;
  logic [2:0] last_cnt;
  obs_t       exp_q [$];
  vec_t       vecs [7];

  mac_operand_sequencer_if #(.N_INPUTS(N_INPUTS)) bus ();

  mac_operand_sequencer #(.N_INPUTS(N_INPUTS), .ITER(ITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t observe();
    obs_t o;
    o.an  = bus.An;
    o.wn  = bus.Wn;
    o.cnt = bus.counter;
    o.st  = bus.start;
    o.sp  = bus.stop;
    o.bz  = bus.busy;
    o.dn  = bus.done;
    return o;
  endfunction

  function automatic obs_t mk(input logic [7:0] an, input logic [7:0] wn, input logic [2:0] c,
                              input logic st, input logic sp, input logic bz, input logic dn);
    obs_t o;
    o.an  = an;
    o.wn  = wn;
    o.cnt = c;
    o.st  = st;
    o.sp  = sp;
    o.bz  = bz;
    o.dn  = dn;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected per-cycle output trace starting the cycle after go, ending with one idle cycle.
  task automatic build_expected(input int np);
    int n;
    n = (np > N_INPUTS) ? N_INPUTS : np;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      bit skip;
      skip = 1'b0;
`ifdef SEQ_ZERO_SKIP_EN
      skip = (mdl_a[i] == 8'd0) || (mdl_w[i] == 8'd0);
`endif
      if (skip) begin
        exp_q.push_back(mk(last_an, last_wn, last_cnt, 1'b0, 1'b0, 1'b1, 1'b0));
      end else begin
        last_an = mdl_a[i];
        last_wn = mdl_w[i];
        for (int c = 0; c < ITER; c++)
          exp_q.push_back(mk(last_an, last_wn, 3'(c), (c == 0), 1'b0, 1'b1, 1'b0));
        last_cnt = 3'(ITER - 1);
        exp_q.push_back(mk(last_an, last_wn, last_cnt, 1'b0, 1'b1, 1'b1, 1'b0));
      end
    end
    exp_q.push_back(mk(last_an, last_wn, last_cnt, 1'b0, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(mk(last_an, last_wn, last_cnt, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic write_pair(input int addr, input logic [7:0] a, input logic [7:0] w);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(addr);
    bus.wr_a    = a;
    bus.wr_w    = w;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (addr < N_INPUTS) begin
      mdl_a[addr] = a;
      mdl_w[addr] = w;
    end
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_an  = 8'd0;
    last_wn  = 8'd0;
    last_cnt = 3'd0;
    check(tag, 32'(observe()), 32'd0);
  endtask

  // mode 0: quiet; 1: random go/write/num_pairs noise while busy; 2: write addr0=(9,9) while busy
  task automatic run_eval(input int np, input int mode, input string tag);
    build_expected(np);
    bus.go        = 1'b1;
    bus.num_pairs = 4'(np);
    foreach (exp_q[k]) begin
      @(negedge clk);
      bus.go    = 1'b0;
      bus.wr_en = 1'b0;
      check($sformatf("%s[%0d]", tag, k), 32'(observe()), 32'(exp_q[k]));
      if (exp_q[k].bz) begin
        if (mode == 1) begin
          bus.go        = 1'($urandom_range(0, 1));
          bus.wr_en     = 1'($urandom_range(0, 1));
          bus.wr_addr   = 3'($urandom);
          bus.wr_a      = 8'($urandom);
          bus.wr_w      = 8'($urandom);
          bus.num_pairs = 4'($urandom);
        end else if (mode == 2) begin
          bus.wr_en   = 1'b1;
          bus.wr_addr = 3'd0;
          bus.wr_a    = 8'd9;
          bus.wr_w    = 8'd9;
        end
      end
    end
    bus.go    = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  initial begin
    int cyc, stops, starts, done_at, nw, np;
    logic [7:0] ra, rw;

    vecs[0] = '{0, 0, 1};
    vecs[1] = '{1, 1, 10};
    vecs[2] = '{2, 2, 19};
    vecs[3] = '{5, 5, 46};
    vecs[4] = '{8, 8, 73};
    vecs[5] = '{11, 8, 73};
    vecs[6] = '{15, 8, 73};

    rst           = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_a      = '0;
    bus.wr_w      = '0;
    bus.num_pairs = '0;
    bus.go        = 1'b0;
    @(negedge clk);
    apply_reset("reset_outputs");

    for (int i = 0; i < N_INPUTS; i++) write_pair(i, 8'(i + 1), 8'(2 * i + 3));

    // Pair count, clamping and done latency
    for (int v = 0; v < 7; v++) begin
      cyc     = 0;
      stops   = 0;
      starts  = 0;
      done_at = -1;
      bus.go        = 1'b1;
      bus.num_pairs = 4'(vecs[v].np);
      while (done_at < 0 && cyc < 200) begin
        @(negedge clk);
        bus.go = 1'b0;
        cyc++;
        if (bus.start) starts++;
        if (bus.stop) stops++;
        if (bus.done) done_at = cyc;
      end
      check($sformatf("tbl%0d_stops", v), stops, vecs[v].exp_stops);
      check($sformatf("tbl%0d_starts", v), starts, vecs[v].exp_stops);
      check($sformatf("tbl%0d_done_cycle", v), done_at, vecs[v].exp_done_cyc);
      @(negedge clk);
      check($sformatf("tbl%0d_busy_after_done", v), 32'(bus.busy), 32'd0);
    end
    apply_reset("reset_after_table");

    write_pair(0, 8'd3, 8'd5);
    write_pair(1, 8'd2, 8'd7);
    run_eval(2, 0, "two_pairs");
    run_eval(0, 0, "zero_pairs");
    run_eval(2, 2, "busy_write");
    run_eval(2, 0, "rerun_after_busy_write");

    // Reset while pair 1 is in RUN
    bus.go        = 1'b1;
    bus.num_pairs = 4'd2;
    repeat (12) begin
      @(negedge clk);
      bus.go = 1'b0;
    end
    check("midrun_pair1_running", 32'(bus.start | bus.stop | bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_reset_outputs", 32'(observe()), 32'd0);
    rst = 1'b0;
    last_an  = 8'd0;
    last_wn  = 8'd0;
    last_cnt = 3'd0;
    repeat (3) begin
      @(negedge clk);
      check("midrun_idle_after_reset", 32'(observe()), 32'd0);
    end
    run_eval(2, 0, "replay_after_reset");

    run_eval(N_INPUTS + 3, 1, "clamp_go_noise");

`ifdef SEQ_ZERO_SKIP_EN
    write_pair(0, 8'd0, 8'd4);
    write_pair(1, 8'd6, 8'd0);
    write_pair(2, 8'd2, 8'd2);
    run_eval(3, 0, "zero_skip");
    write_pair(2, 8'd0, 8'd2);
    run_eval(3, 0, "zero_skip_all");
`endif

    for (int r = 0; r < 25; r++) begin
      nw = $urandom_range(0, 4);
      for (int j = 0; j < nw; j++) begin
        ra = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        rw = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        write_pair($urandom_range(0, N_INPUTS - 1), ra, rw);
      end
      np = $urandom_range(0, N_INPUTS + 3);
      run_eval(np, 1, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
- Drives the operand and control side of the neuron MAC: it issues An, Wn, counter, start and stop for one neuron evaluation.
- Host preloads up to N_INPUTS activation/weight pairs into an internal buffer, then pulses go.
- The block replays each pair through the CORDIC multiply schedule (start pulse, ITER counter steps, stop pulse) so the MAC accumulates one product per pair.
- Signals done when the last pair's stop has been issued.

Parameters:
- N_INPUTS, 8: operand-pair buffer depth; maximum pairs per evaluation.
- ITER, 8: CORDIC iterations per product; legal range 1..8, since the counter port is 3 bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  buffer write strobe.
- wr_addr  input  $clog2(N_INPUTS)  buffer write index.
- wr_a  input  8  activation to store.
- wr_w  input  8  weight to store.
- num_pairs  input  $clog2(N_INPUTS)+1  pairs to process; sampled on go.
- go  input  1  start-evaluation pulse.
- An  output  8  activation to MAC (registered).
- Wn  output  8  weight to MAC (registered).
- counter  output  3  CORDIC iteration index to MAC (registered).
- start  output  1  MAC start pulse (registered).
- stop  output  1  MAC stop/accumulate pulse (registered).
- busy  output  1  high from the cycle after go until done, inclusive.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - State goes to IDLE.
  - An, Wn, counter, start, stop, busy, done all 0.
  - Pair index and iteration count 0.
  - Buffer contents are not reset; they are retained.
  - Reset mid-evaluation aborts immediately; no further start/stop is issued.
- Buffer writes:
  - N_INPUTS x 16 bit array.
  - A write occurs when wr_en=1 and busy=0.
  - wr_en is ignored while busy.
  - Out-of-range wr_addr is ignored.
- States: IDLE, START, RUN, STOP, DONE.
- IDLE:
  - go=1 latches num_pairs, clamped to N_INPUTS.
  - If the latched value is 0, go to DONE; else go to START with pair index 0.
  - go is ignored in every state other than IDLE.
- START (1 cycle):
  - An/Wn load buffer[idx]; start=1; counter=0.
  - Next state is RUN if ITER>1, else STOP.
- RUN:
  - start=0; counter increments by 1 per cycle.
  - Leave for STOP in the cycle after counter reaches ITER-1.
- STOP (1 cycle):
  - stop=1; counter holds ITER-1; An/Wn held.
  - If idx = num_pairs-1, go to DONE; else increment idx and go to START (back-to-back, no idle gap).
- DONE (1 cycle): done=1, busy=1; then IDLE.
- Signal rules:
  - An/Wn are stable from START through STOP of a pair.
  - In IDLE they hold their last values.
  - start and stop are never high in the same cycle.
- Timing:
  - Each pair occupies ITER+1 cycles.
  - With go sampled at cycle t: first start at t+1; done at t+1+num_pairs*(ITER+1); busy deasserts at the following cycle.
- The block does not clear the MAC accumulator; clearing is the system's responsibility.

Optional Feature:
- Macro: SEQ_ZERO_SKIP_EN.
- Defined: while in START/STOP transition logic, any pair whose activation or weight is 0 is skipped entirely.
  - No start, stop or counter activity is issued for a skipped pair.
  - The scan over skipped pairs takes 1 cycle per skipped pair with start=stop=0.
  - If every pair is skipped, done is asserted after the scan.
- Not defined: every pair is issued regardless of value, and timing is exactly as in Behaviour.

Test Plan:
- Load pairs (3,5),(2,7); num_pairs=2; ITER=8; pulse go at t -> start at t+1 and t+10; stop at t+9 and t+18; counter 0..7 each pair; done at t+19; An/Wn=3/5 then 2/7.
- num_pairs=0, go -> done one cycle after go; start and stop never asserted.
- Write wr_en during busy with wr_addr=0, wr_a=9 -> buffer[0] unchanged; a re-run issues the original An.
- Assert rst during RUN of pair 1 -> next cycle all outputs 0 and state IDLE; a subsequent go replays from pair 0 using the retained buffer.
- go pulses while busy, plus num_pairs=N_INPUTS+3 on the initial go -> extra go pulses ignored; exactly N_INPUTS stop pulses issued.
- SEQ_ZERO_SKIP_EN defined; pairs (0,4),(6,0),(2,2); num_pairs=3 -> exactly one start/stop sequence, with An=2, Wn=2; done asserted.
